// File: rtl/note_pkg.sv
// note_pkg: shared constants and types for the note detector.
// Holds the nominal half-period table (clk cycles) and the FSM state type.
package note_pkg;

    localparam int NOTE_W    = 5;
    localparam int NUM_NOTES = 19;

    // Nominal half-period per note code; entry 0 is silence and never matched.
    localparam int H [NUM_NOTES+1] = '{
        0,
        47801, 45126, 42589, 40192, 37936, 35816, 33829, 31887, 30120, 28409,
        26824, 25329, 23900, 22563, 21295, 18968, 17909, 12665, 9485
    };

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        LOCKED
    } state_t;

endpackage

// File: rtl/note_classifier.sv
// note_classifier: maps a measured half-period to a note code.
// Returns the lowest table entry within +/-TOL of the measurement, or 0.
module note_classifier
    import note_pkg::*;
#(
    parameter int TOL   = 64,
    parameter int CNT_W = 17
) (
    input  logic [CNT_W-1:0]  d,
    output logic [NOTE_W-1:0] code
);

    int dv;

    // Scan from the top of the table down so the lowest matching code wins.
    always_comb begin
        code = '0;
        dv   = int'(d);
        for (int n = NUM_NOTES; n >= 1; n--) begin
            if ((dv >= H[n] - TOL) && (dv <= H[n] + TOL)) begin
                code = NOTE_W'(n);
            end
        end
    end

endmodule

// File: rtl/note_detector.sv
// note_detector: measures the half-period of an incoming square wave and
// reports the matching note code, with confirmation and silence timeout.
// Optional input deglitch filter: define NOTE_DETECTOR_DEGLITCH_EN.
module note_detector
    import note_pkg::*;
#(
    parameter int TOL      = 64,
    parameter int CONFIRM  = 3,
    parameter int TIMEOUT  = 100000,
    parameter int DEGLITCH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wave_in,
    output logic [NOTE_W-1:0] note,
    output logic              note_stb,
    output logic              locked
);

    localparam int              CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [2:0]      CONFIRM_V = 3'(CONFIRM);

    logic              s1, s2, s3;
    logic              lvl;
    logic              wave_edge;
    logic [CNT_W-1:0]  cnt;
    logic [NOTE_W-1:0] cls;
    logic [NOTE_W-1:0] cand, next_cand;
    logic [2:0]        match, next_match;
    state_t            state;

    // Two-flop synchronizer for the asynchronous wave input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= wave_in;
            s2 <= s1;
        end
    end

`ifdef NOTE_DETECTOR_DEGLITCH_EN
    localparam int DG_W = $clog2(DEGLITCH + 1);

    logic [DG_W-1:0] dg_cnt;
    logic            filt;

    // Accept a new level only after it has held for DEGLITCH cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt   <= 1'b0;
            dg_cnt <= '0;
        end else if (s2 == filt) begin
            dg_cnt <= '0;
        end else if (dg_cnt == DG_W'(DEGLITCH - 1)) begin
            filt   <= s2;
            dg_cnt <= '0;
        end else begin
            dg_cnt <= dg_cnt + 1'b1;
        end
    end

    assign lvl = filt;
`else
    logic unused_deglitch;

    assign unused_deglitch = (DEGLITCH != 0);
    assign lvl             = s2;
`endif

    // Delay flop for edge detection on the conditioned level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3 <= 1'b0;
        end else begin
            s3 <= lvl;
        end
    end

    assign wave_edge = lvl ^ s3;

    // Half-period counter: restarts at 1 on each edge, saturates at TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (wave_edge) begin
            cnt <= CNT_W'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    note_classifier #(
        .TOL   (TOL),
        .CNT_W (CNT_W)
    ) u_classifier (
        .d    (cnt),
        .code (cls)
    );

    // Candidate tracking: a silent result clears the run, a new note reseeds it.
    always_comb begin
        next_cand  = cand;
        next_match = match;
        if (cls == '0) begin
            next_match = '0;
        end else if (cls == cand) begin
            next_match = match + 1'b1;
        end else begin
            next_cand  = cls;
            next_match = 3'd1;
        end
    end

    // Main FSM with registered note, strobe and lock outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            note     <= '0;
            note_stb <= 1'b0;
            locked   <= 1'b0;
            cand     <= '0;
            match    <= '0;
        end else begin
            note_stb <= 1'b0;
            if (wave_edge) begin
                if (state == IDLE) begin
                    state <= MEASURE;
                end else if (!(state == LOCKED && cls == note)) begin
                    cand  <= next_cand;
                    match <= next_match;
                    if (next_match == CONFIRM_V) begin
                        state    <= LOCKED;
                        locked   <= 1'b1;
                        note     <= next_cand;
                        note_stb <= (next_cand != note);
                    end else begin
                        state  <= MEASURE;
                        locked <= 1'b0;
                    end
                end
            end else if (cnt == CNT_MAX) begin
                state    <= IDLE;
                locked   <= 1'b0;
                note     <= '0;
                match    <= '0;
                note_stb <= (note != '0);
            end
        end
    end

endmodule

// File: doc/note_detector.md
# note_detector

- Receive-side counterpart of the square-wave tone generator: measures the half-period of an incoming square wave in `clk` cycles and decodes it to the 5-bit note code (0 = silence, 1..19 = table notes).
- Sits between a wave input pin (loop-back or external source) and game logic.
- Reports the note the player or tester is producing.
- Debounces pitch changes and falls back to silence when the wave stops.

## Interface
- `TOL`, 64: accepted ± deviation, in cycles, of a measured half-period from the table value; must be < 529.
- `CONFIRM`, 3: consecutive matching half-periods required to lock a note; 1..7.
- `TIMEOUT`, 100000: cycles without an edge before declaring silence; must be > 47801.
- `DEGLITCH`, 16: input stability requirement in cycles; used only when the filter is compiled in.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `wave_in` in 1: asynchronous square-wave input.
- `note` out 5: decoded note code, held until the next confirmed note or a timeout.
- `note_stb` out 1: one-cycle pulse in the cycle `note` changes value.
- `locked` out 1: high while in LOCKED.

## Operation
- **Input conditioning:** `wave_in` passes through a 2-flop synchronizer `s1`→`s2` and a delay flop `s3`. `edge = s2 ^ s3`.
- **Counter `cnt`:** width `$clog2(TIMEOUT+1)`.
  - Loaded with 1 on an edge cycle.
  - Otherwise increments, saturating at `TIMEOUT`.
  - At an edge, measured half-period `d = cnt`.
- **Note table:** nominal half-period per note is `H[n] = threshold[n] + 1`. Thresholds for n = 1..19: 47800, 45125, 42588, 40191, 37935, 35815, 33828, 31886, 30119, 28408, 26823, 25328, 23899, 22562, 21294, 18967, 17908, 12664, 9484.
- **Classification:** `cls(d)` is the lowest n with |d − H[n]| ≤ `TOL`, else 0.
- **States:**
  - **IDLE:** `note` = 0. On edge → MEASURE. No classification, because the first edge has no reference.
  - **MEASURE:** on edge, `c = cls(d)`:
    - If c = 0 → `match` = 0.
    - Else if c == `cand` → `match` += 1.
    - Else → `cand` = c, `match` = 1.
    - When `match` reaches `CONFIRM` → LOCKED, `note` = `cand`. Pulse `note_stb` if the value differs from the previous `note`.
  - **LOCKED:** on edge with `cls(d)` == `note`, stay. Any other result → MEASURE with `cand`/`match` seeded as above; `note` is held.
  - **Timeout:** in any state, `cnt == TIMEOUT` with no edge → IDLE, `note` = 0, `match` = 0. Pulse `note_stb` if `note` was nonzero.
- **Simultaneous events:** an edge in the same cycle as timeout is treated as an edge.
- **Reset:** all flops, including the synchronizers, clear immediately; `note` = 0, `note_stb` = 0, `locked` = 0, state IDLE. Deasserting mid-wave restarts from IDLE.

## Timing
- State, `note`, `note_stb` and `locked` update on the clock edge of the edge-detect cycle.
- Latency: `note` changes on the 3rd rising `clk` after the `wave_in` transition that completes the confirming half-period. It is 3 + `DEGLITCH` with the filter.
- Lock needs `CONFIRM` + 1 wave transitions from IDLE.
- Silence is reported `TIMEOUT` cycles after the last detected edge.
- `note_stb` never lasts more than one cycle and never fires without a value change.

## Configuration
- **`NOTE_DETECTOR_DEGLITCH_EN` defined:**
  - A filter sits between `s2` and `s3`.
  - The filtered level changes only after `s2` has held the new value for `DEGLITCH` consecutive cycles.
  - Pulses shorter than `DEGLITCH` are invisible.
  - Latency is constant, so measured periods are unchanged.
- **Undefined:** no filter; `s3` samples `s2` directly. A glitch produces two short half-periods classified 0, which clears `match` or drops LOCKED to MEASURE.

## Structure
- **Package `note_pkg`:**
  - `NOTE_W` = 5 and `NUM_NOTES` = 19.
  - The `H[]` half-period constant array.
  - The state enum (IDLE, MEASURE, LOCKED).
- **Sub-module `note_classifier`:** combinational; `d`, `TOL` → note code.
- **Top level:** holds the synchronizer, optional deglitch filter, counter and FSM.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-wave → `note` = 0, `note_stb` = 0, `locked` = 0 immediately. After release, the first edge enters MEASURE only.
- **Lock from IDLE:** square wave with half-period 47801 → after the 4th transition `note` = 1, `locked` = 1, exactly one `note_stb` pulse.
- **Tolerance:** half-period 9485+40 → `note` = 19. Half-period 9485+70 → stays MEASURE, `note` = 0, no strobe.
- **Pitch change:** locked on 1, switch to half-period 12665 → `note` holds 1, `locked` = 0 for 2 transitions. On the 3rd, `note` = 18 with a single strobe.
- **Timeout:** stop the wave while locked on 5 → exactly `TIMEOUT` cycles after the last edge, `note` = 0, strobe, state IDLE.
- **Glitch:** inject a 10-cycle pulse mid-half-period while locked on 8.
  - Macro defined: lock and `note` unaffected.
  - Macro undefined: `locked` drops, relock after 3 clean half-periods.
